// File: rtl/inst_split_pipe_if.sv
// inst_split_pipe_if: instruction-in / decoded-fields-out handshake bundle
interface inst_split_pipe_if #(
    parameter int INST_W = 24,
    parameter int OPC_W  = 6,
    parameter int REG_W  = 5,
    parameter int FUNC_W = 3,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [INST_W-1:0]       inst;
    logic                    out_valid;
    logic                    out_ready;
    logic [OPC_W-1:0]        opc;
    logic [REG_W-1:0]        rs;
    logic [REG_W-1:0]        rt;
    logic [FUNC_W-1:0]       funcode;
    logic [INST_W-OPC_W-1:0] jba;
    logic [DATA_W-1:0]       imm;
    logic [CNT_W-1:0]        dec_count;
    modport master (
        output flush, in_valid, inst, out_ready,
        input  in_ready, out_valid, opc, rs, rt, funcode, jba, imm, dec_count
    );
    modport slave (
        input  flush, in_valid, inst, out_ready,
        output in_ready, out_valid, opc, rs, rt, funcode, jba, imm, dec_count
    );
endinterface

// File: rtl/inst_split_pipe.sv
// inst_split_pipe: registered instruction field splitter with 2-entry skid buffer and decode counter
module inst_split_pipe #(
    parameter int INST_W = 24,
    parameter int OPC_W  = 6,
    parameter int REG_W  = 5,
    parameter int FUNC_W = 3,
    parameter int IMM_W  = 8,
    parameter int DATA_W = 24,
    parameter bit SEXT   = 1'b1,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    inst_split_pipe_if.slave bus
);
    typedef struct packed {
        logic [OPC_W-1:0]        opc;
        logic [REG_W-1:0]        rs;
        logic [REG_W-1:0]        rt;
        logic [FUNC_W-1:0]       funcode;
        logic [INST_W-OPC_W-1:0] jba;
        logic [DATA_W-1:0]       imm;
    } dec_t;
    if (OPC_W + 2*REG_W > INST_W || FUNC_W > INST_W || IMM_W > DATA_W) begin : g_bad_params
        $error("inst_split_pipe: inconsistent field widths");
    end
    dec_t             dec, or_q, or_d, sk_q, sk_d;
    logic             or_v_q, or_v_d, sk_v_q, sk_v_d;
    logic             acc, xfer, load_or, load_sk;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        dec.opc     = bus.inst[INST_W-1 -: OPC_W];
        dec.rs      = bus.inst[INST_W-OPC_W-1 -: REG_W];
        dec.rt      = bus.inst[INST_W-OPC_W-REG_W-1 -: REG_W];
        dec.funcode = bus.inst[FUNC_W-1:0];
        dec.jba     = bus.inst[INST_W-OPC_W-1:0];
        dec.imm     = SEXT ? DATA_W'($signed(bus.inst[IMM_W-1:0])) : DATA_W'(bus.inst[IMM_W-1:0]);
        // an accept during flush is dropped, a transfer during flush still retires
        acc     = bus.in_valid && !sk_v_q && !bus.flush;
        xfer    = or_v_q && bus.out_ready;
        load_or = acc && (!or_v_q || xfer);
        load_sk = acc && or_v_q && !xfer;
        or_d    = (xfer && sk_v_q) ? sk_q : load_or ? dec : or_q;
        sk_d    = load_sk ? dec : sk_q;
        or_v_d  = !bus.flush && (load_or || sk_v_q || (or_v_q && !xfer));
        sk_v_d  = !bus.flush && (load_sk || (sk_v_q && !xfer));
        cnt_d   = cnt_q + CNT_W'(xfer);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_v_q <= 1'b0;
            sk_v_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            or_q   <= or_d;
            sk_q   <= sk_d;
            or_v_q <= or_v_d;
            sk_v_q <= sk_v_d;
            cnt_q  <= cnt_d;
        end
    end
    assign bus.in_ready  = !sk_v_q;
    assign bus.out_valid = or_v_q;
    assign bus.opc       = or_q.opc;
    assign bus.rs        = or_q.rs;
    assign bus.rt        = or_q.rt;
    assign bus.funcode   = or_q.funcode;
    assign bus.jba       = or_q.jba;
    assign bus.imm       = or_q.imm;
    assign bus.dec_count = cnt_q;
endmodule

// File: tb/tb_inst_split_pipe.sv
// tb_inst_split_pipe: directed checks of field split, skid buffering, flush, reset and counter wrap
module tb_inst_split_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    inst_split_pipe_if #(.CNT_W(16)) b0 ();
    inst_split_pipe_if #(.CNT_W(16)) b1 ();
    inst_split_pipe_if #(.CNT_W(4))  b2 ();
    inst_split_pipe #(.SEXT(1'b1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
    inst_split_pipe #(.SEXT(1'b0), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
    inst_split_pipe #(.SEXT(1'b1), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(b2));
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        b0.flush = 0; b0.in_valid = 0; b0.inst = '0; b0.out_ready = 0;
        b1.flush = 0; b1.in_valid = 0; b1.inst = '0; b1.out_ready = 0;
        b2.flush = 0; b2.in_valid = 0; b2.inst = '0; b2.out_ready = 0;
        step(); step();
        rst = 1'b0;
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", b0.out_valid); end
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", b0.in_ready); end
        checks++; if (b0.dec_count !== 16'd0) begin errors++; $display("FAIL rst_dec_count got=%0d exp=0", b0.dec_count); end
        checks++; if (b0.opc !== 6'h0 || b0.jba !== 18'h0 || b0.imm !== 24'h0) begin errors++; $display("FAIL rst_fields got opc=%h jba=%h imm=%h exp=0", b0.opc, b0.jba, b0.imm); end
    endtask
    task automatic test_fields();
        b0.inst = 24'h8A2B07; b0.in_valid = 1; b0.out_ready = 1;
        step();
        b0.in_valid = 0;
        checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL fld_out_valid got=%b exp=1", b0.out_valid); end
        checks++; if (b0.opc !== 6'h22) begin errors++; $display("FAIL fld_opc got=%h exp=22", b0.opc); end
        checks++; if (b0.rs !== 5'h11) begin errors++; $display("FAIL fld_rs got=%h exp=11", b0.rs); end
        checks++; if (b0.rt !== 5'h0B) begin errors++; $display("FAIL fld_rt got=%h exp=0b", b0.rt); end
        checks++; if (b0.funcode !== 3'h7) begin errors++; $display("FAIL fld_funcode got=%h exp=7", b0.funcode); end
        checks++; if (b0.jba !== 18'h22B07) begin errors++; $display("FAIL fld_jba got=%h exp=22b07", b0.jba); end
        checks++; if (b0.imm !== 24'h000007) begin errors++; $display("FAIL fld_imm got=%h exp=000007", b0.imm); end
        checks++; if (b0.dec_count !== 16'd0) begin errors++; $display("FAIL fld_cnt_before got=%0d exp=0", b0.dec_count); end
        step();
        checks++; if (b0.dec_count !== 16'd1) begin errors++; $display("FAIL fld_cnt_after got=%0d exp=1", b0.dec_count); end
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL fld_drained got=%b exp=0", b0.out_valid); end
    endtask
    task automatic test_sext();
        b0.inst = 24'h000087; b0.in_valid = 1; b0.out_ready = 1;
        b1.inst = 24'h000087; b1.in_valid = 1; b1.out_ready = 1;
        step();
        b0.in_valid = 0; b1.in_valid = 0;
        checks++; if (b0.imm !== 24'hFFFF87) begin errors++; $display("FAIL sext1_imm got=%h exp=ffff87", b0.imm); end
        checks++; if (b1.imm !== 24'h000087) begin errors++; $display("FAIL sext0_imm got=%h exp=000087", b1.imm); end
        step();
        checks++; if (b0.dec_count !== 16'd2) begin errors++; $display("FAIL sext_cnt got=%0d exp=2", b0.dec_count); end
    endtask
    task automatic test_back_to_back();
        b0.out_ready = 0; b0.in_valid = 1; b0.inst = 24'h111111;
        step();
        checks++; if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_loaded got in_ready=%b out_valid=%b exp=1/1", b0.in_ready, b0.out_valid); end
        b0.inst = 24'h222222;
        step();
        checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got=%b exp=0", b0.in_ready); end
        checks++; if (b0.opc !== 6'h04 || b0.jba !== 18'h11111) begin errors++; $display("FAIL b2b_hold_a1 got opc=%h jba=%h exp=04/11111", b0.opc, b0.jba); end
        b0.inst = 24'h333333;
        step(); step();
        checks++; if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall got in_ready=%b out_valid=%b exp=0/1", b0.in_ready, b0.out_valid); end
        checks++; if (b0.opc !== 6'h04 || b0.jba !== 18'h11111) begin errors++; $display("FAIL b2b_hold_a2 got opc=%h jba=%h exp=04/11111", b0.opc, b0.jba); end
        b0.out_ready = 1;
        step();
        checks++; if (b0.opc !== 6'h08 || b0.jba !== 18'h22222 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b got opc=%h jba=%h v=%b exp=08/22222/1", b0.opc, b0.jba, b0.out_valid); end
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen got=%b exp=1", b0.in_ready); end
        step();
        b0.in_valid = 0;
        checks++; if (b0.opc !== 6'h0C || b0.jba !== 18'h33333 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_c got opc=%h jba=%h v=%b exp=0c/33333/1", b0.opc, b0.jba, b0.out_valid); end
        step();
        checks++; if (b0.out_valid !== 1'b0 || b0.dec_count !== 16'd5) begin errors++; $display("FAIL b2b_done got v=%b cnt=%0d exp=0/5", b0.out_valid, b0.dec_count); end
    endtask
    task automatic test_flush();
        b0.out_ready = 0; b0.in_valid = 1; b0.inst = 24'h444444;
        step();
        b0.inst = 24'h555555;
        step();
        checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL fl_full got=%b exp=0", b0.in_ready); end
        b0.flush = 1; b0.inst = 24'h666666;
        step();
        b0.flush = 0; b0.in_valid = 0;
        checks++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL fl_empty got v=%b rdy=%b exp=0/1", b0.out_valid, b0.in_ready); end
        b0.out_ready = 1;
        step(); step(); step();
        checks++; if (b0.out_valid !== 1'b0 || b0.dec_count !== 16'd5) begin errors++; $display("FAIL fl_gone got v=%b cnt=%0d exp=0/5", b0.out_valid, b0.dec_count); end
        b0.in_valid = 1; b0.inst = 24'h777777;
        step();
        b0.in_valid = 0; b0.out_ready = 0;
        checks++; if (b0.opc !== 6'h1D || b0.jba !== 18'h37777 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL fl_next got opc=%h jba=%h v=%b exp=1d/37777/1", b0.opc, b0.jba, b0.out_valid); end
        b0.flush = 1; b0.out_ready = 1;
        step();
        b0.flush = 0;
        checks++; if (b0.out_valid !== 1'b0 || b0.dec_count !== 16'd6) begin errors++; $display("FAIL fl_xfer_counts got v=%b cnt=%0d exp=0/6", b0.out_valid, b0.dec_count); end
    endtask
    task automatic test_wrap();
        b2.out_ready = 1; b2.in_valid = 1;
        for (int i = 0; i < 17; i++) begin
            b2.inst = 24'(i);
            step();
        end
        checks++; if (b2.dec_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got=%0d exp=0", b2.dec_count); end
        b2.in_valid = 0;
        step();
        checks++; if (b2.dec_count !== 4'd1) begin errors++; $display("FAIL wrap_17 got=%0d exp=1", b2.dec_count); end
        checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%b exp=0", b2.out_valid); end
    endtask
    task automatic test_rst_mid();
        b0.out_ready = 0; b0.in_valid = 1; b0.inst = 24'hABCDEF;
        step();
        b0.inst = 24'h123456;
        step();
        b0.in_valid = 0;
        checks++; if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL rm_full got rdy=%b v=%b exp=0/1", b0.in_ready, b0.out_valid); end
        rst = 1;
        step();
        rst = 0;
        checks++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL rm_state got v=%b rdy=%b exp=0/1", b0.out_valid, b0.in_ready); end
        checks++; if (b0.dec_count !== 16'd0) begin errors++; $display("FAIL rm_cnt got=%0d exp=0", b0.dec_count); end
        checks++; if (b0.opc !== 6'h0 || b0.rs !== 5'h0 || b0.rt !== 5'h0 || b0.funcode !== 3'h0 || b0.jba !== 18'h0 || b0.imm !== 24'h0) begin errors++; $display("FAIL rm_fields got opc=%h rs=%h rt=%h fc=%h jba=%h imm=%h exp=0", b0.opc, b0.rs, b0.rt, b0.funcode, b0.jba, b0.imm); end
        b0.out_ready = 1;
        step();
        checks++; if (b0.out_valid !== 1'b0 || b0.dec_count !== 16'd0) begin errors++; $display("FAIL rm_no_ghost got v=%b cnt=%0d exp=0/0", b0.out_valid, b0.dec_count); end
    endtask
    initial begin
        test_reset();
        test_fields();
        test_sext();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
